// File: rtl/alu_share_arbiter.sv
// Two-requester arbiter in front of one shared ALU: accept, issue for one cycle, return a tagged response.
// Define ALU_ARB_FIXED_PRIORITY_EN for fixed priority (requester 0 first); the default build is round-robin.
module alu_share_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [2*WIDTH-1:0] req_a,
  input  logic [2*WIDTH-1:0] req_b,
  input  logic [5:0]         req_op,
  output logic [WIDTH-1:0]   alu_a,
  output logic [WIDTH-1:0]   alu_b,
  output logic [2:0]         alu_select,
  input  logic [WIDTH-1:0]   alu_y,
  input  logic               alu_zero,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic               resp_id,
  output logic [WIDTH-1:0]   resp_y,
  output logic               resp_zero,
  output logic               resp_err,
  output logic [1:0]         dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
  // req_ready is only ever raised in IDLE toward a requester whose valid is high;
  // resp_valid stays high with stable payload until resp_ready is seen.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t             state_q;
  logic [WIDTH-1:0]   alu_a_q;
  logic [WIDTH-1:0]   alu_b_q;
  logic [2:0]         alu_sel_q;
  logic               id_q;
  logic               resp_valid_q;
  logic               resp_id_q;
  logic [WIDTH-1:0]   resp_y_q;
  logic               resp_zero_q;
  logic               resp_err_q;
`ifndef ALU_ARB_FIXED_PRIORITY_EN
  logic               last_grant_q;
`endif

  logic               winner;
  logic               accept;
  logic [WIDTH-1:0]   sel_a;
  logic [WIDTH-1:0]   sel_b;
  logic [2:0]         sel_op;
  logic               illegal_op;

  always_comb begin
    winner = 1'b0;
`ifdef ALU_ARB_FIXED_PRIORITY_EN
    winner = ~req_valid[0];
`else
    if (req_valid == 2'b11) begin
      winner = ~last_grant_q;
    end else begin
      winner = ~req_valid[0];
    end
`endif
  end

  // rst_n gating keeps req_ready low while reset is held.
  assign accept    = rst_n && (state_q == IDLE) && (req_valid != 2'b00);
  assign req_ready = accept ? (winner ? 2'b10 : 2'b01) : 2'b00;

  assign sel_a  = winner ? req_a[2*WIDTH-1:WIDTH] : req_a[WIDTH-1:0];
  assign sel_b  = winner ? req_b[2*WIDTH-1:WIDTH] : req_b[WIDTH-1:0];
  assign sel_op = winner ? req_op[5:3] : req_op[2:0];

  // Opcodes 100 and 101 have no ALU function.
  assign illegal_op = (alu_sel_q[2:1] == 2'b10);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_sel_q    <= 3'b000;
      id_q         <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= 1'b0;
      resp_y_q     <= '0;
      resp_zero_q  <= 1'b0;
      resp_err_q   <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIORITY_EN
      last_grant_q <= 1'b1;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            alu_a_q   <= sel_a;
            alu_b_q   <= sel_b;
            alu_sel_q <= sel_op;
            id_q      <= winner;
            state_q   <= ISSUE;
          end
        end
        ISSUE: begin
          alu_a_q      <= '0;
          alu_b_q      <= '0;
          alu_sel_q    <= 3'b000;
          resp_id_q    <= id_q;
          resp_valid_q <= 1'b1;
          if (illegal_op) begin
            resp_y_q    <= '0;
            resp_zero_q <= 1'b0;
            resp_err_q  <= 1'b1;
          end else begin
            resp_y_q    <= alu_y;
            resp_zero_q <= alu_zero;
            resp_err_q  <= 1'b0;
          end
          state_q <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIORITY_EN
            last_grant_q <= resp_id_q;
`endif
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_select = alu_sel_q;
  assign resp_valid = resp_valid_q;
  assign resp_id    = resp_id_q;
  assign resp_y     = resp_y_q;
  assign resp_zero  = resp_zero_q;
  assign resp_err   = resp_err_q;
  assign dbg_state  = state_q;

endmodule
